// File: rtl/hsem_lock_ctrl.sv
//-----------------------------------------------------------------------------
// hsem_lock_ctrl
//
// Semaphore lock engine of the HSEM block. It takes decoded lock, unlock and
// clear-all requests and holds the lock state of every semaphore: the lock
// bit, the owner core ID and, optionally, the owner process ID. It answers
// each request one cycle later with the resulting status of the addressed
// semaphore. It raises sticky error flags and pulses a free event for each
// semaphore that goes from locked to free.
//
// Configuration macros:
//   HSEM_PROCID_CHECK_EN - when defined, the process ID is stored, and write-
//                          lock and unlock ownership requires both core_id and
//                          proc_id to match. When undefined, only core_id is
//                          stored and compared, and rsp_data[7:0] reads 0.
//   SEMERR_WIDTH         - width of the semerr output (default 4, must be >= 4).
//
// Ports:
//   hclk        in   system clock
//   hresetn     in   synchronous active-low reset
//   req_valid   in   request strobe, one request per cycle
//   req_type    in   00 read-lock, 01 write-lock, 10 unlock, 11 clear-all
//   req_idx     in   semaphore index (ignored for clear-all)
//   req_core_id in   requesting core
//   req_proc_id in   requesting process (ignored for read-lock)
//   req_key     in   key for clear-all; also the value loaded by key_wr_en
//   key_wr_en   in   load the clear key from req_key
//   err_clr     in   clear all semerr bits
//   rsp_valid   out  response strobe, one cycle after req_valid
//   rsp_data    out  {lock, 15'b0, core[7:0], proc[7:0]} after the update
//   sem_locked  out  lock bit per semaphore
//   free_evt    out  one-cycle pulse per semaphore on locked->free
//   semerr      out  sticky errors: [0] unlock by non-owner, [1] lock
//                    contention, [2] index out of range, [3] key mismatch
//-----------------------------------------------------------------------------
`ifndef SEMERR_WIDTH
`define SEMERR_WIDTH 4
`endif

module hsem_lock_ctrl #(
    parameter int NUM_SEM   = 32,
    parameter int CORE_ID_W = 4,
    parameter int PROC_ID_W = 8
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     req_valid,
    input  logic [1:0]               req_type,
    input  logic [5:0]               req_idx,
    input  logic [CORE_ID_W-1:0]     req_core_id,
    input  logic [PROC_ID_W-1:0]     req_proc_id,
    input  logic [15:0]              req_key,
    input  logic                     key_wr_en,
    input  logic                     err_clr,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic [NUM_SEM-1:0]       sem_locked,
    output logic [NUM_SEM-1:0]       free_evt,
    output logic [`SEMERR_WIDTH-1:0] semerr
);

    localparam int SEMERR_W = `SEMERR_WIDTH;

    localparam logic [1:0] REQ_RDLOCK = 2'b00;
    localparam logic [1:0] REQ_WRLOCK = 2'b01;
    localparam logic [1:0] REQ_UNLOCK = 2'b10;
    localparam logic [1:0] REQ_CLEAR  = 2'b11;

    // Per-semaphore state
    logic [NUM_SEM-1:0]   lock_reg;
    logic [NUM_SEM-1:0]   lock_next;
    logic [CORE_ID_W-1:0] core_reg  [NUM_SEM];
    logic [CORE_ID_W-1:0] core_next [NUM_SEM];
`ifdef HSEM_PROCID_CHECK_EN
    logic [PROC_ID_W-1:0] proc_reg  [NUM_SEM];
    logic [PROC_ID_W-1:0] proc_next [NUM_SEM];
`else
    logic                 unused_proc;
    assign unused_proc = ^req_proc_id;
`endif

    logic [15:0]          key_reg;
    logic                 rsp_valid_reg;
    logic [31:0]          rsp_data_reg;
    logic [31:0]          rsp_data_next;
    logic [NUM_SEM-1:0]   free_evt_reg;
    logic [NUM_SEM-1:0]   free_next;
    logic [3:0]           semerr_reg;
    logic [3:0]           semerr_next;

    // Request decode
    logic is_rd, is_wr, is_unl, is_clr;
    logic idx_ok, key_ok;
    logic [NUM_SEM-1:0] hit_v;
    logic [NUM_SEM-1:0] wr_err_v;
    logic [NUM_SEM-1:0] unl_err_v;

    assign is_rd  = (req_type == REQ_RDLOCK);
    assign is_wr  = (req_type == REQ_WRLOCK);
    assign is_unl = (req_type == REQ_UNLOCK);
    assign is_clr = (req_type == REQ_CLEAR);
    assign idx_ok = (req_idx < 6'(NUM_SEM));
    // Compare against the stored key: a key loaded in the same cycle only
    // applies to later requests.
    assign key_ok = (req_key == key_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEM; gi++) begin : g_sem
            logic hit;
            logic own;
            logic do_lock;
            logic do_free;

            assign hit = idx_ok && (req_idx == 6'(gi));
`ifdef HSEM_PROCID_CHECK_EN
            assign own = (core_reg[gi] == req_core_id) && (proc_reg[gi] == req_proc_id);
`else
            assign own = (core_reg[gi] == req_core_id);
`endif
            assign do_lock = req_valid && hit && !lock_reg[gi] && (is_rd || is_wr);
            // Clear-all matches on core only, regardless of the process ID.
            assign do_free = req_valid && lock_reg[gi] &&
                             ((is_unl && hit && own) ||
                              (is_clr && key_ok && (core_reg[gi] == req_core_id)));

            assign lock_next[gi] = do_lock ? 1'b1 : (do_free ? 1'b0 : lock_reg[gi]);
            assign core_next[gi] = do_lock ? req_core_id : (do_free ? '0 : core_reg[gi]);
`ifdef HSEM_PROCID_CHECK_EN
            // Read-lock records process 0.
            assign proc_next[gi] = do_lock ? (is_wr ? req_proc_id : '0)
                                           : (do_free ? '0 : proc_reg[gi]);
`endif
            assign free_next[gi] = do_free;
            assign hit_v[gi]     = hit;
            assign wr_err_v[gi]  = req_valid && is_wr  && hit && lock_reg[gi] && !own;
            assign unl_err_v[gi] = req_valid && is_unl && hit && lock_reg[gi] && !own;
        end
    endgenerate

    // Response reflects the addressed semaphore after this cycle's update.
    always_comb begin
        logic                 sel_lock;
        logic [CORE_ID_W-1:0] sel_core;
        logic [7:0]           sel_proc;
        sel_lock      = 1'b0;
        sel_core      = '0;
        sel_proc      = '0;
        rsp_data_next = '0;
        for (int i = 0; i < NUM_SEM; i++) begin
            if (hit_v[i]) begin
                sel_lock = lock_next[i];
                sel_core = core_next[i];
`ifdef HSEM_PROCID_CHECK_EN
                sel_proc = 8'(proc_next[i]);
`endif
            end
        end
        if (req_valid && idx_ok && !is_clr) begin
            rsp_data_next = {sel_lock, 15'b0, 8'(sel_core), sel_proc};
        end
    end

    // A new error in the same cycle as err_clr survives the clear.
    always_comb begin
        logic [3:0] new_err;
        new_err[0] = |unl_err_v;
        new_err[1] = |wr_err_v;
        new_err[2] = req_valid && !is_clr && !idx_ok;
        new_err[3] = req_valid && is_clr && !key_ok;
        semerr_next = (err_clr ? 4'b0 : semerr_reg) | new_err;
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            lock_reg      <= '0;
            key_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            free_evt_reg  <= '0;
            semerr_reg    <= '0;
            for (int i = 0; i < NUM_SEM; i++) begin
                core_reg[i] <= '0;
`ifdef HSEM_PROCID_CHECK_EN
                proc_reg[i] <= '0;
`endif
            end
        end else begin
            lock_reg      <= lock_next;
            rsp_valid_reg <= req_valid;
            rsp_data_reg  <= rsp_data_next;
            free_evt_reg  <= free_next;
            semerr_reg    <= semerr_next;
            if (key_wr_en) begin
                key_reg <= req_key;
            end
            for (int i = 0; i < NUM_SEM; i++) begin
                core_reg[i] <= core_next[i];
`ifdef HSEM_PROCID_CHECK_EN
                proc_reg[i] <= proc_next[i];
`endif
            end
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign sem_locked = lock_reg;
    assign free_evt   = free_evt_reg;
    assign semerr     = SEMERR_W'(semerr_reg);

endmodule

// File: tb/tb_hsem_lock_ctrl.sv
//-----------------------------------------------------------------------------
// tb_hsem_lock_ctrl
//
// Directed testbench for hsem_lock_ctrl with NUM_SEM=32. Each task drives one
// scenario and checks the registered outputs 1 ns after the clock edge.
// Expected proc bytes depend on HSEM_PROCID_CHECK_EN.
//-----------------------------------------------------------------------------
`ifndef SEMERR_WIDTH
`define SEMERR_WIDTH 4
`endif

module tb_hsem_lock_ctrl;

    localparam int SW = `SEMERR_WIDTH;
`ifdef HSEM_PROCID_CHECK_EN
    localparam logic [7:0] P22 = 8'h22;
    localparam bit         PROC_CHK = 1'b1;
`else
    localparam logic [7:0] P22 = 8'h00;
    localparam bit         PROC_CHK = 1'b0;
`endif

    logic          hclk;
    logic          hresetn;
    logic          req_valid;
    logic [1:0]    req_type;
    logic [5:0]    req_idx;
    logic [3:0]    req_core_id;
    logic [7:0]    req_proc_id;
    logic [15:0]   req_key;
    logic          key_wr_en;
    logic          err_clr;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [31:0]   sem_locked;
    logic [31:0]   free_evt;
    logic [SW-1:0] semerr;

    int tests_run;
    int tests_failed;

    hsem_lock_ctrl #(.NUM_SEM(32), .CORE_ID_W(4), .PROC_ID_W(8)) dut (
        .hclk(hclk), .hresetn(hresetn), .req_valid(req_valid), .req_type(req_type),
        .req_idx(req_idx), .req_core_id(req_core_id), .req_proc_id(req_proc_id),
        .req_key(req_key), .key_wr_en(key_wr_en), .err_clr(err_clr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sem_locked(sem_locked),
        .free_evt(free_evt), .semerr(semerr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Advance one edge, then release the single-cycle strobes.
    task automatic step();
        @(posedge hclk);
        #1;
        req_valid = 1'b0;
        key_wr_en = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [5:0] idx,
                         input logic [3:0] core, input logic [7:0] proc,
                         input logic [15:0] key);
        req_valid   = 1'b1;
        req_type    = t;
        req_idx     = idx;
        req_core_id = core;
        req_proc_id = proc;
        req_key     = key;
        step();
        $display("[TB] req type=%0d idx=%0d core=%0d proc=%h key=%h -> rsp_valid=%0b rsp_data=%h locked=%h free=%h semerr=%h",
                 t, idx, core, proc, key, rsp_valid, rsp_data, sem_locked, free_evt, semerr);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        step();
        step();
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests_run++;
        if (rsp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        tests_run++;
        if (sem_locked !== 32'h0) begin tests_failed++; $display("FAIL reset_locked: got %h expected 0", sem_locked); end
        tests_run++;
        if (free_evt !== 32'h0 || semerr !== SW'(0)) begin
            tests_failed++; $display("FAIL reset_evt_err: got free=%h semerr=%h expected 0/0", free_evt, semerr);
        end
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_write_lock();
        issue(2'b01, 6'd3, 4'd1, 8'h22, 16'h0);
        tests_run++;
        if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL wl_rsp_valid: got %b expected 1", rsp_valid); end
        tests_run++;
        if (rsp_data !== {24'h8000_01, P22}) begin tests_failed++; $display("FAIL wl_rsp_data: got %h expected %h", rsp_data, {24'h8000_01, P22}); end
        tests_run++;
        if (sem_locked !== 32'h8 || semerr !== SW'(0)) begin
            tests_failed++; $display("FAIL wl_state: got locked=%h semerr=%h expected 00000008/0", sem_locked, semerr);
        end
        step();
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            tests_failed++; $display("FAIL wl_idle_rsp: got valid=%b data=%h expected 0/0", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_contention();
        issue(2'b01, 6'd3, 4'd2, 8'h22, 16'h0);
        tests_run++;
        if (rsp_data !== {24'h8000_01, P22}) begin tests_failed++; $display("FAIL cont_rsp_data: got %h expected %h", rsp_data, {24'h8000_01, P22}); end
        tests_run++;
        if (semerr !== SW'(2)) begin tests_failed++; $display("FAIL cont_semerr: got %h expected 2", semerr); end
        clear_errors();
        tests_run++;
        if (semerr !== SW'(0)) begin tests_failed++; $display("FAIL cont_err_clr: got %h expected 0", semerr); end
        // Same core, different process: error only when process IDs are checked.
        issue(2'b01, 6'd3, 4'd1, 8'h33, 16'h0);
        tests_run++;
        if (semerr !== (PROC_CHK ? SW'(2) : SW'(0)) || rsp_data !== {24'h8000_01, P22}) begin
            tests_failed++; $display("FAIL cont_same_core: got semerr=%h data=%h expected %h/%h",
                                     semerr, rsp_data, PROC_CHK ? SW'(2) : SW'(0), {24'h8000_01, P22});
        end
        clear_errors();
    endtask

    task automatic test_unlock();
        issue(2'b10, 6'd3, 4'd2, 8'h22, 16'h0);
        tests_run++;
        if (semerr !== SW'(1) || sem_locked !== 32'h8) begin
            tests_failed++; $display("FAIL unl_foreign: got semerr=%h locked=%h expected 1/00000008", semerr, sem_locked);
        end
        clear_errors();
        issue(2'b10, 6'd3, 4'd1, 8'h22, 16'h0);
        tests_run++;
        if (free_evt !== 32'h8) begin tests_failed++; $display("FAIL unl_free_evt: got %h expected 00000008", free_evt); end
        tests_run++;
        if (rsp_data !== 32'h0 || sem_locked !== 32'h0) begin
            tests_failed++; $display("FAIL unl_state: got data=%h locked=%h expected 0/0", rsp_data, sem_locked);
        end
        step();
        tests_run++;
        if (free_evt !== 32'h0) begin tests_failed++; $display("FAIL unl_pulse_width: got %h expected 0", free_evt); end
        issue(2'b10, 6'd3, 4'd1, 8'h22, 16'h0);
        tests_run++;
        if (semerr !== SW'(0) || free_evt !== 32'h0 || rsp_data !== 32'h0) begin
            tests_failed++; $display("FAIL unl_already_free: got semerr=%h free=%h data=%h expected 0/0/0", semerr, free_evt, rsp_data);
        end
    endtask

    task automatic test_read_lock();
        issue(2'b00, 6'd5, 4'd4, 8'h77, 16'h0);
        tests_run++;
        if (rsp_data !== 32'h8000_0400) begin tests_failed++; $display("FAIL rl_first: got %h expected 80000400", rsp_data); end
        issue(2'b00, 6'd5, 4'd6, 8'h11, 16'h0);
        tests_run++;
        if (rsp_data !== 32'h8000_0400) begin tests_failed++; $display("FAIL rl_second: got %h expected 80000400", rsp_data); end
        tests_run++;
        if (semerr !== SW'(0) || sem_locked !== 32'h20) begin
            tests_failed++; $display("FAIL rl_state: got semerr=%h locked=%h expected 0/00000020", semerr, sem_locked);
        end
        issue(2'b10, 6'd5, 4'd4, 8'h00, 16'h0);
        tests_run++;
        if (free_evt !== 32'h20 || sem_locked !== 32'h0) begin
            tests_failed++; $display("FAIL rl_release: got free=%h locked=%h expected 00000020/0", free_evt, sem_locked);
        end
    endtask

    task automatic test_clear_all();
        req_key   = 16'hA5A5;
        key_wr_en = 1'b1;
        step();
        issue(2'b01, 6'd0, 4'd1, 8'h01, 16'h0);
        issue(2'b01, 6'd1, 4'd1, 8'h02, 16'h0);
        issue(2'b01, 6'd2, 4'd2, 8'h03, 16'h0);
        tests_run++;
        if (sem_locked !== 32'h7) begin tests_failed++; $display("FAIL clr_setup: got %h expected 00000007", sem_locked); end
        issue(2'b11, 6'd2, 4'd1, 8'h00, 16'hA5A5);
        tests_run++;
        if (free_evt !== 32'h3) begin tests_failed++; $display("FAIL clr_free_evt: got %h expected 00000003", free_evt); end
        tests_run++;
        if (sem_locked !== 32'h4 || rsp_data !== 32'h0 || semerr !== SW'(0)) begin
            tests_failed++; $display("FAIL clr_state: got locked=%h data=%h semerr=%h expected 00000004/0/0", sem_locked, rsp_data, semerr);
        end
        step();
        tests_run++;
        if (free_evt !== 32'h0) begin tests_failed++; $display("FAIL clr_pulse_width: got %h expected 0", free_evt); end
        issue(2'b11, 6'd0, 4'd2, 8'h00, 16'h1234);
        tests_run++;
        if (semerr !== SW'(8) || sem_locked !== 32'h4) begin
            tests_failed++; $display("FAIL clr_bad_key: got semerr=%h locked=%h expected 8/00000004", semerr, sem_locked);
        end
        clear_errors();
        // Key loaded in the same cycle as the clear-all: old key still compared.
        key_wr_en = 1'b1;
        issue(2'b11, 6'd0, 4'd2, 8'h00, 16'h5555);
        tests_run++;
        if (semerr !== SW'(8) || free_evt !== 32'h0) begin
            tests_failed++; $display("FAIL clr_key_same_cycle: got semerr=%h free=%h expected 8/0", semerr, free_evt);
        end
        issue(2'b11, 6'd0, 4'd2, 8'h00, 16'h5555);
        tests_run++;
        if (free_evt !== 32'h4 || sem_locked !== 32'h0) begin
            tests_failed++; $display("FAIL clr_new_key: got free=%h locked=%h expected 00000004/0", free_evt, sem_locked);
        end
    endtask

    task automatic test_index_range();
        // semerr[3] is still set; err_clr with a new error keeps only the new bit.
        err_clr = 1'b1;
        issue(2'b01, 6'd40, 4'd1, 8'h22, 16'h0);
        tests_run++;
        if (semerr !== SW'(4)) begin tests_failed++; $display("FAIL idx_semerr: got %h expected 4", semerr); end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || sem_locked !== 32'h0) begin
            tests_failed++; $display("FAIL idx_rsp: got valid=%b data=%h locked=%h expected 1/0/0", rsp_valid, rsp_data, sem_locked);
        end
        issue(2'b00, 6'd32, 4'd1, 8'h00, 16'h0);
        tests_run++;
        if (rsp_data !== 32'h0 || sem_locked !== 32'h0) begin
            tests_failed++; $display("FAIL idx_boundary: got data=%h locked=%h expected 0/0", rsp_data, sem_locked);
        end
        clear_errors();
        issue(2'b00, 6'd31, 4'd9, 8'h00, 16'h0);
        tests_run++;
        if (rsp_data !== 32'h8000_0900 || sem_locked !== 32'h8000_0000 || semerr !== SW'(0)) begin
            tests_failed++; $display("FAIL idx_top: got data=%h locked=%h semerr=%h expected 80000900/80000000/0", rsp_data, sem_locked, semerr);
        end
    endtask

    task automatic test_reset_midop();
        issue(2'b01, 6'd7, 4'd3, 8'h44, 16'h0);
        tests_run++;
        if (sem_locked !== 32'h8000_0080) begin tests_failed++; $display("FAIL rst_mid_lock: got %h expected 80000080", sem_locked); end
        // Request in flight while reset is sampled: response must be dropped.
        req_valid   = 1'b1;
        req_type    = 2'b01;
        req_idx     = 6'd8;
        req_core_id = 4'd3;
        hresetn     = 1'b0;
        step();
        $display("[TB] reset mid-op -> rsp_valid=%0b rsp_data=%h locked=%h", rsp_valid, rsp_data, sem_locked);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            tests_failed++; $display("FAIL rst_mid_rsp: got valid=%b data=%h expected 0/0", rsp_valid, rsp_data);
        end
        tests_run++;
        if (sem_locked !== 32'h0 || semerr !== SW'(0)) begin
            tests_failed++; $display("FAIL rst_mid_state: got locked=%h semerr=%h expected 0/0", sem_locked, semerr);
        end
        hresetn = 1'b1;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        hresetn      = 1'b0;
        req_valid    = 1'b0;
        req_type     = 2'b00;
        req_idx      = 6'd0;
        req_core_id  = 4'd0;
        req_proc_id  = 8'd0;
        req_key      = 16'd0;
        key_wr_en    = 1'b0;
        err_clr      = 1'b0;
        test_reset();
        test_write_lock();
        test_contention();
        test_unlock();
        test_read_lock();
        test_clear_all();
        test_index_range();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hsem_lock_ctrl.md
Name: hsem_lock_ctrl

Overview:
- Semaphore lock engine of the HSEM block, directly upstream of the interrupt/error controller.
- Takes decoded lock/unlock/clear requests from the AHB slave decode and holds per-semaphore lock state (lock bit, owner core ID, process ID).
- Drives the sticky `semerr` vector consumed by the error register.
- Pulses per-semaphore free events that the interrupt controller uses for task-switch notification.

Parameters:
- NUM_SEM, 32, number of semaphores; legal range 1..32.
- CORE_ID_W, 4, width of the owner core ID.
- PROC_ID_W, 8, width of the owner process ID.

Ports:
- hclk  input  1  system clock.
- hresetn  input  1  reset; synchronous, active-low.
- req_valid  input  1  request strobe; one request per cycle, never stalled.
- req_type  input  2  00 read-lock (1-step), 01 write-lock (2-step), 10 unlock, 11 clear-all for core.
- req_idx  input  6  semaphore index.
- req_core_id  input  CORE_ID_W  requesting core.
- req_proc_id  input  PROC_ID_W  requesting process; ignored for read-lock.
- req_key  input  16  key supplied with clear-all.
- key_wr_en  input  1  load `clr_key` from `req_key`.
- err_clr  input  1  clear all `semerr` bits; same pulse as the error-clear register enable.
- rsp_valid  output  1  response strobe, one cycle after `req_valid`.
- rsp_data  output  32  {lock, 15'b0, core_id zero-extended to 8, proc_id}, i.e. bit31 lock, bits15:8 core, bits7:0 proc.
- sem_locked  output  NUM_SEM  lock bit per semaphore.
- free_evt  output  NUM_SEM  one-cycle pulse per semaphore on a locked->free transition.
- semerr  output  `SEMERR_WIDTH`  sticky error flags; bits above 3 tied to 0.

Behaviour:
- Reset (hresetn=0 at a hclk edge):
  - all semaphores free, owner fields 0, `clr_key`=0.
  - `rsp_valid`=0, `rsp_data`=0, `free_evt`=0, `semerr`=0.
  - Reset mid-operation discards any in-flight response.
- Latency: state update and response both register on the edge after `req_valid`. `rsp_data` reflects state after the update.
- Read-lock:
  - If free: lock, owner=`req_core_id`, proc=0.
  - If locked: no change, no error.
  - `rsp_data` = resulting status; the requester compares core_id to detect success.
- Write-lock:
  - If free: lock with `req_core_id`/`req_proc_id`.
  - If locked by the same owner: no change, no error.
  - If locked by another owner: no change; set semerr[1] (lock contention).
- Unlock:
  - If owner matches: free the semaphore, clear owner fields, pulse `free_evt[idx]` in the same cycle as `rsp_valid`.
  - If locked by another owner: no change; set semerr[0].
  - If already free: no change, no error.
- Clear-all:
  - If `req_key`==`clr_key`: free every semaphore whose core_id==`req_core_id` (proc ignored). Pulse `free_evt` for each freed semaphore. `rsp_data`=0.
  - Key mismatch: no change; set semerr[3].
- Index range: `req_idx` >= NUM_SEM on types 00/01/10 gives no state change, `rsp_data`=0, and sets semerr[2]. `req_idx` is ignored for clear-all.
- `semerr` bits are sticky until `err_clr`.
  - If `err_clr` and a new error occur in the same cycle, the new error wins: the bit reads 1 next cycle.
- `key_wr_en` concurrent with a clear-all request: the compare uses the old key; the new key takes effect next cycle.
- `rsp_valid`=0 implies `rsp_data`=0.
- Ownership match is core_id AND proc_id, unless reduced by the optional feature.

Optional Feature:
- Macro: HSEM_PROCID_CHECK_EN.
- Defined: owner match requires equal core_id and proc_id for write-lock and unlock.
- Undefined:
  - proc_id is neither stored nor compared; ownership is core_id only.
  - `rsp_data`[7:0] reads 0.
  - Write-lock by the same core with a different proc_id is a no-error no-op.

Test Plan:
- Reset, then write-lock idx 3 core 1 proc 0x22 -> next cycle `rsp_valid`=1, `rsp_data`=0x8000_0122, `sem_locked`[3]=1, `semerr`=0.
- Write-lock idx 3 core 2 while held by core 1 -> `rsp_data`=0x8000_0122, semerr[1]=1. Subsequent `err_clr` -> `semerr`=0 next cycle.
- Unlock idx 3 core 1 proc 0x22 -> `free_evt`[3] single-cycle pulse, `rsp_data`=0. Unlock idx 3 by core 2 when locked -> semerr[0]=1, lock kept.
- Read-lock idx 5 core 4 twice, second read from core 6 -> both `rsp_data`=0x8000_0400, no error.
- Load key 0xA5A5, lock idx 0,1 (core 1) and idx 2 (core 2), clear-all core 1 key 0xA5A5 -> `free_evt`=0x3 one cycle, idx 2 still locked. Clear-all with key 0x1234 -> semerr[3]=1.
- Write-lock idx 40 (NUM_SEM=32) -> semerr[2]=1, `rsp_data`=0. Assert hresetn=0 in the cycle after a lock -> `rsp_valid`=0, all semaphores free.
